mux8_scan_ctrl: RTL and testbench

Scan controller wrapped around an 8-to-1 single-bit mux.
- Drives the mux select pins s2/s1/s0 through the enabled channels, lowest index first.
- Waits a programmable settle time on each channel, then samples the mux output y.
- Packs the sampled bits into an 8-bit word and presents it on a valid/ready handshake to downstream logic.

---
 rtl/mux8_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_mux8_scan_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mux8_scan_ctrl.sv
// Scans the enabled inputs of an 8:1 mux and packs the sampled bits into a word (parity via MUX8_SCAN_PARITY_EN).
// Latency: result valid popcount(ch_mask)*DWELL cycles after start (next cycle for an empty mask).
// Backpressure: result held in HOLD until data_ready; start is ignored outside IDLE.
module mux8_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] ch_mask,
  input  logic       y_in,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready
`ifdef MUX8_SCAN_PARITY_EN
  ,
  output logic       parity_out
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  logic [1:0] state;
  logic [7:0] mask;
  logic [2:0] sel;
  logic [3:0] dwell_cnt;
  logic [2:0] first_sel;
  logic [2:0] next_sel;
  logic       more_ch;
  logic [7:0] cap_word;
  logic       par_q;

  // Descending loops leave the lowest qualifying index as the winner.
  always_comb begin
    first_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (ch_mask[i]) first_sel = 3'(i);
    end
    next_sel = sel;
    more_ch  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i > int'(sel))) begin
        next_sel = 3'(i);
        more_ch  = 1'b1;
      end
    end
    cap_word      = data_out;
    cap_word[sel] = y_in;
  end

  assign {s2, s1, s0} = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mask       <= 8'h00;
      sel        <= 3'd0;
      dwell_cnt  <= 4'd0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= 8'h00;
      par_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask      <= ch_mask;
            data_out  <= 8'h00;
            par_q     <= 1'b0;
            dwell_cnt <= 4'd0;
            if (ch_mask != 8'h00) begin
              sel   <= first_sel;
              busy  <= 1'b1;
              state <= SCAN;
            end else begin
              data_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        SCAN: begin
          if (dwell_cnt == DWELL_LAST) begin
            data_out  <= cap_word;
            par_q     <= ^cap_word;
            dwell_cnt <= 4'd0;
            if (more_ch) begin
              sel <= next_sel;
            end else begin
              busy       <= 1'b0;
              data_valid <= 1'b1;
              state      <= HOLD;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          busy       <= 1'b0;
          data_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef MUX8_SCAN_PARITY_EN
  assign parity_out = par_q;
`endif

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed-vector bench for mux8_scan_ctrl: DWELL=2 main instance plus a DWELL=1 instance driven in parallel.
module tb_mux8_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] ch_mask;
  logic       data_ready;
  logic [7:0] mux_in;

  logic       y0, s2_0, s1_0, s0_0, busy0, dv0;
  logic [7:0] dout0;
  logic       y1, s2_1, s1_1, s0_1, busy1, dv1;
  logic [7:0] dout1;
`ifdef MUX8_SCAN_PARITY_EN
  logic       par0, par1;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  assign y0 = mux_in[{s2_0, s1_0, s0_0}];
  assign y1 = mux_in[{s2_1, s1_1, s0_1}];

  mux8_scan_ctrl #(.DWELL(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .y_in(y0),
    .s2(s2_0), .s1(s1_0), .s0(s0_0), .busy(busy0), .data_out(dout0),
    .data_valid(dv0), .data_ready(data_ready)
`ifdef MUX8_SCAN_PARITY_EN
    , .parity_out(par0)
`endif
  );

  mux8_scan_ctrl #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .y_in(y1),
    .s2(s2_1), .s1(s1_1), .s0(s0_1), .busy(busy1), .data_out(dout1),
    .data_valid(dv1), .data_ready(data_ready)
`ifdef MUX8_SCAN_PARITY_EN
    , .parity_out(par1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] inputs;
    logic [7:0] exp_data;
    int         exp_lat;
    logic       exp_par;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Starts a scan, follows it to HOLD on the DWELL=2 instance, then completes the handshake.
  task automatic run_vec(input vec_t v, input string tag);
    logic [2:0] exp_sel[$];
    int cyc, lat0, lat1, sel_err;
    bit busy_gap;
    for (int k = 0; k < 8; k++) begin
      if (v.mask[k]) begin
        exp_sel.push_back(3'(k));
        exp_sel.push_back(3'(k));
      end
    end
    @(negedge clk);
    start = 1'b1; ch_mask = v.mask; mux_in = v.inputs;
    @(negedge clk);
    start = 1'b0; ch_mask = ~v.mask;
    cyc = 0; lat0 = -1; lat1 = -1; sel_err = 0; busy_gap = 1'b0;
    while (cyc < 200) begin
      if (lat1 < 0 && dv1) lat1 = cyc;
      if (dv0) begin
        lat0 = cyc;
        break;
      end
      if (!busy0) busy_gap = 1'b1;
      if (cyc >= exp_sel.size()) sel_err++;
      else if ({s2_0, s1_0, s0_0} != exp_sel[cyc]) sel_err++;
      cyc++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 32'(lat0), 32'(v.exp_lat));
    chk({tag, " latency_dwell1"}, 32'(lat1), 32'(v.exp_lat / 2));
    chk({tag, " sel_sequence_errors"}, 32'(sel_err), 32'd0);
    chk({tag, " busy_during_scan_gap"}, {31'd0, busy_gap}, 32'd0);
    chk({tag, " data_out"}, {24'd0, dout0}, {24'd0, v.exp_data});
    chk({tag, " data_out_dwell1"}, {24'd0, dout1}, {24'd0, v.exp_data});
    chk({tag, " busy_in_hold"}, {31'd0, busy0}, 32'd0);
`ifdef MUX8_SCAN_PARITY_EN
    chk({tag, " parity"}, {31'd0, par0}, {31'd0, v.exp_par});
    chk({tag, " parity_dwell1"}, {31'd0, par1}, {31'd0, v.exp_par});
`endif
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk({tag, " valid_after_handshake"}, {30'd0, dv0, dv1}, 32'd0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{8'hFF, 8'hA5, 8'hA5, 16, 1'b0};
    vecs[1] = '{8'h81, 8'hFF, 8'h81,  4, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h00,  0, 1'b0};
    vecs[3] = '{8'h07, 8'h07, 8'h07,  6, 1'b1};
    vecs[4] = '{8'h5A, 8'hFF, 8'h5A,  8, 1'b0};
    vecs[5] = '{8'h10, 8'hFF, 8'h10,  2, 1'b1};
    vecs[6] = '{8'hF0, 8'h0F, 8'h00,  8, 1'b0};
    vecs[7] = '{8'h3C, 8'hAA, 8'h28,  8, 1'b0};

    rst_n = 1'b0; start = 1'b0; ch_mask = 8'h00; data_ready = 1'b0; mux_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset sel", {29'd0, s2_0, s1_0, s0_0}, 32'd0);
    chk("reset busy_valid", {30'd0, busy0, dv0}, 32'd0);
    chk("reset data_out", {24'd0, dout0}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a full scan.
    @(negedge clk);
    start = 1'b1; ch_mask = 8'hFF; mux_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midscan sel", {29'd0, s2_0, s1_0, s0_0}, 32'd2);
    chk("midscan partial", {24'd0, dout0}, 32'h03);
    rst_n = 1'b0;
    #1;
    chk("async_reset sel", {26'd0, s2_0, s1_0, s0_0, s2_1, s1_1, s0_1}, 32'd0);
    chk("async_reset busy_valid", {28'd0, busy0, dv0, busy1, dv1}, 32'd0);
    chk("async_reset data_out", {16'd0, dout0, dout1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[1], "after_reset");

    // Backpressure and ignored start pulses.
    @(negedge clk);
    start = 1'b1; ch_mask = 8'hFF; mux_in = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; ch_mask = 8'h00;
    @(negedge clk);
    start = 1'b0;
    cyc = 4;
    while (!dv0 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk("bp latency", 32'(cyc), 32'd16);
    chk("bp data_out", {24'd0, dout0}, 32'hA5);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      ch_mask = 8'h00;
      mux_in = 8'h00;
      @(negedge clk);
      chk($sformatf("bp hold%0d data_out", i), {24'd0, dout0}, 32'hA5);
      chk($sformatf("bp hold%0d valid", i), {31'd0, dv0}, 32'd1);
    end
    start = 1'b0;
    chk("bp hold sel", {29'd0, s2_0, s1_0, s0_0}, 32'd7);
    data_ready = 1'b1; start = 1'b1; ch_mask = 8'hFF;
    @(negedge clk);
    data_ready = 1'b0; start = 1'b0;
    chk("bp handshake valid_busy", {28'd0, busy0, dv0, busy1, dv1}, 32'd0);
    @(negedge clk);
    chk("bp start_not_queued", {28'd0, busy0, dv0, busy1, dv1}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
